// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register for the 16-bit, 16-register CPU.
// Drives register-file read addresses, detects load-use hazards and registers decoded fields for EX.
module id_ex_stage #(
  parameter int DSIZE = 16,
  parameter int RSIZE = 4,
  parameter int ISIZE = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             IF_Valid,
  input  logic [ISIZE-1:0] IF_Instr,
  input  logic [DSIZE-1:0] IF_PC,
  input  logic             Flush,
  output logic [RSIZE-1:0] RAddr1,
  output logic [RSIZE-1:0] RAddr2,
  input  logic [DSIZE-1:0] RData1,
  input  logic [DSIZE-1:0] RData2,
  output logic             Stall,
  output logic             EX_Valid,
  output logic [3:0]       EX_Op,
  output logic [RSIZE-1:0] EX_Rd,
  output logic [DSIZE-1:0] EX_A,
  output logic [DSIZE-1:0] EX_B,
  output logic [DSIZE-1:0] EX_Imm,
  output logic [DSIZE-1:0] EX_PC,
  output logic             EX_RegWrite,
  output logic             EX_MemRead,
  output logic             EX_MemWrite
);

  logic [3:0]       op;
  logic [RSIZE-1:0] f1, f2, f3;
  logic [7:0]       lo8;
  logic [11:0]      lo12;

  assign op   = IF_Instr[15:12];
  assign f1   = IF_Instr[11:8];
  assign f2   = IF_Instr[7:4];
  assign f3   = IF_Instr[3:0];
  assign lo8  = IF_Instr[7:0];
  assign lo12 = IF_Instr[11:0];

  logic [RSIZE-1:0] dec_rd;
  logic [RSIZE-1:0] raddr [2];
  logic [1:0]       use_port;
  logic [DSIZE-1:0] dec_imm;
  logic             dec_regwrite, dec_memread, dec_memwrite;

  always_comb begin
    dec_rd       = '0;
    raddr[0]     = '0;
    raddr[1]     = '0;
    use_port     = 2'b00;
    dec_imm      = '0;
    dec_regwrite = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        dec_rd       = f1;
        raddr[0]     = f2;
        raddr[1]     = f3;
        use_port     = 2'b11;
        dec_regwrite = 1'b1;
      end
      // Shifts carry the amount in f3; the second port address is not a real read.
      4'h4, 4'h5, 4'h6, 4'h7: begin
        dec_rd       = f1;
        raddr[0]     = f2;
        raddr[1]     = f3;
        use_port     = 2'b01;
        dec_imm      = {{(DSIZE-4){1'b0}}, f3};
        dec_regwrite = 1'b1;
      end
      4'h8: begin
        dec_rd       = f1;
        raddr[0]     = f2;
        use_port     = 2'b01;
        dec_imm      = {{(DSIZE-4){f3[3]}}, f3};
        dec_regwrite = 1'b1;
        dec_memread  = 1'b1;
      end
      4'h9: begin
        raddr[0]     = f2;
        raddr[1]     = f1;
        use_port     = 2'b11;
        dec_imm      = {{(DSIZE-4){f3[3]}}, f3};
        dec_memwrite = 1'b1;
      end
      4'hA, 4'hB: begin
        dec_rd       = f1;
        raddr[0]     = f1;
        use_port     = 2'b01;
        dec_imm      = {{(DSIZE-8){1'b0}}, lo8};
        dec_regwrite = 1'b1;
      end
      4'hC: begin
        dec_rd  = f1;
        dec_imm = {{(DSIZE-8){lo8[7]}}, lo8};
      end
      4'hD: dec_imm = {{(DSIZE-12){1'b0}}, lo12};
      4'hE: begin
        dec_rd       = '1;
        dec_imm      = {{(DSIZE-12){1'b0}}, lo12};
        dec_regwrite = 1'b1;
      end
      default: ;
    endcase
    if (dec_rd == '0) dec_regwrite = 1'b0;
  end

  assign RAddr1 = raddr[0];
  assign RAddr2 = raddr[1];

  logic             ex_valid_reg, ex_regwrite_reg, ex_memread_reg, ex_memwrite_reg;
  logic [3:0]       ex_op_reg;
  logic [RSIZE-1:0] ex_rd_reg;
  logic [DSIZE-1:0] ex_a_reg, ex_b_reg, ex_imm_reg, ex_pc_reg;
  logic [1:0]       hit;

  for (genvar gi = 0; gi < 2; gi++) begin : g_hazard
    assign hit[gi] = use_port[gi] && (raddr[gi] == ex_rd_reg);
  end

  assign Stall = Reset && IF_Valid && ex_valid_reg && ex_memread_reg &&
                 (ex_rd_reg != '0) && (|hit);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      ex_valid_reg    <= 1'b0;
      ex_op_reg       <= '0;
      ex_rd_reg       <= '0;
      ex_a_reg        <= '0;
      ex_b_reg        <= '0;
      ex_imm_reg      <= '0;
      ex_pc_reg       <= '0;
      ex_regwrite_reg <= 1'b0;
      ex_memread_reg  <= 1'b0;
      ex_memwrite_reg <= 1'b0;
    end else begin
      ex_op_reg  <= op;
      ex_rd_reg  <= dec_rd;
      ex_a_reg   <= RData1;
      ex_b_reg   <= RData2;
      ex_imm_reg <= dec_imm;
      ex_pc_reg  <= IF_PC;
      // Flush, bubble and empty slots all leave a dead EX slot with no side effects.
      if (Flush || Stall || !IF_Valid) begin
        ex_valid_reg    <= 1'b0;
        ex_regwrite_reg <= 1'b0;
        ex_memread_reg  <= 1'b0;
        ex_memwrite_reg <= 1'b0;
      end else begin
        ex_valid_reg    <= 1'b1;
        ex_regwrite_reg <= dec_regwrite;
        ex_memread_reg  <= dec_memread;
        ex_memwrite_reg <= dec_memwrite;
      end
    end
  end

  assign EX_Valid    = ex_valid_reg;
  assign EX_Op       = ex_op_reg;
  assign EX_Rd       = ex_rd_reg;
  assign EX_A        = ex_a_reg;
  assign EX_B        = ex_b_reg;
  assign EX_Imm      = ex_imm_reg;
  assign EX_PC       = ex_pc_reg;
  assign EX_RegWrite = ex_regwrite_reg;
  assign EX_MemRead  = ex_memread_reg;
  assign EX_MemWrite = ex_memwrite_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a per-cycle reference model plus literal spot checks.
module tb_id_ex_stage;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        IF_Valid = 1'b0;
  logic [15:0] IF_Instr = 16'hF000;
  logic [15:0] IF_PC = '0;
  logic        Flush = 1'b0;
  logic [3:0]  RAddr1, RAddr2;
  logic [15:0] RData1 = '0, RData2 = '0;
  logic        Stall, EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite;
  logic [3:0]  EX_Op, EX_Rd;
  logic [15:0] EX_A, EX_B, EX_Imm, EX_PC;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .Clock(Clock), .Reset(Reset), .IF_Valid(IF_Valid), .IF_Instr(IF_Instr), .IF_PC(IF_PC),
    .Flush(Flush), .RAddr1(RAddr1), .RAddr2(RAddr2), .RData1(RData1), .RData2(RData2),
    .Stall(Stall), .EX_Valid(EX_Valid), .EX_Op(EX_Op), .EX_Rd(EX_Rd), .EX_A(EX_A),
    .EX_B(EX_B), .EX_Imm(EX_Imm), .EX_PC(EX_PC), .EX_RegWrite(EX_RegWrite),
    .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference decode written straight from the instruction-class table.
  typedef struct packed {
    logic [3:0]  rd, r1, r2;
    logic        u1, u2, r2c, rdc, immc, rw, mr, mw;
    logic [15:0] imm;
  } dec_t;

  function automatic dec_t decode(input logic [15:0] i);
    dec_t d;
    int   opn;
    d = '0;
    d.r2c = 1'b1;
    opn = int'(i[15:12]);
    if (opn <= 7) begin
      d.rd = i[11:8]; d.r1 = i[7:4]; d.r2 = i[3:0];
      d.u1 = 1; d.u2 = (opn < 4); d.r2c = (opn < 4); d.rw = 1; d.rdc = 1;
      if (opn >= 4) begin d.imm = {12'h0, i[3:0]}; d.immc = 1; end
    end else if (opn == 8) begin
      d.rd = i[11:8]; d.r1 = i[7:4]; d.u1 = 1; d.rw = 1; d.mr = 1; d.rdc = 1;
      d.imm = {{12{i[3]}}, i[3:0]}; d.immc = 1;
    end else if (opn == 9) begin
      d.r1 = i[7:4]; d.r2 = i[11:8]; d.u1 = 1; d.u2 = 1; d.mw = 1;
      d.imm = {{12{i[3]}}, i[3:0]}; d.immc = 1;
    end else if (opn == 10 || opn == 11) begin
      d.rd = i[11:8]; d.r1 = i[11:8]; d.u1 = 1; d.rw = 1; d.rdc = 1;
      d.imm = {8'h0, i[7:0]}; d.immc = 1;
    end else if (opn == 12) begin
      d.rd = i[11:8]; d.rdc = 1; d.imm = {{8{i[7]}}, i[7:0]}; d.immc = 1;
    end else if (opn == 13) begin
      d.imm = {4'h0, i[11:0]}; d.immc = 1;
    end else if (opn == 14) begin
      d.rd = 4'd15; d.rw = 1; d.rdc = 1; d.imm = {4'h0, i[11:0]}; d.immc = 1;
    end
    if (d.rd == 0) d.rw = 0;
    return d;
  endfunction

  // Model of the EX slot contents, updated once per cycle.
  bit          m_known = 0, m_ctrl_known = 0, m_fields_known = 0, m_rdc = 0, m_immc = 0;
  bit          m_valid = 0, m_rw = 0, m_mr = 0, m_mw = 0;
  logic [3:0]  m_op = 0, m_rd = 0;
  logic [15:0] m_a = 0, m_b = 0, m_imm = 0, m_pc = 0;

  always @(negedge Clock) begin
    dec_t d;
    bit   exp_stall;
    d = decode(IF_Instr);
    exp_stall = Reset && IF_Valid && m_known && m_valid && m_mr && (m_rd != 0) &&
                ((d.u1 && d.r1 == m_rd) || (d.u2 && d.r2 == m_rd));
    chk("m_raddr1", RAddr1, d.r1);
    if (d.r2c) chk("m_raddr2", RAddr2, d.r2);
    if (m_known) begin
      chk("m_stall", Stall, exp_stall);
      chk("m_valid", EX_Valid, m_valid);
      if (m_ctrl_known) begin
        chk("m_regwrite", EX_RegWrite, m_rw);
        chk("m_memread", EX_MemRead, m_mr);
        chk("m_memwrite", EX_MemWrite, m_mw);
      end
      if (m_fields_known) begin
        chk("m_op", EX_Op, m_op);
        chk("m_pc", EX_PC, m_pc);
        chk("m_a", EX_A, m_a);
        chk("m_b", EX_B, m_b);
        if (m_rdc) chk("m_rd", EX_Rd, m_rd);
        if (m_immc) chk("m_imm", EX_Imm, m_imm);
      end
    end
    if (!Reset) begin
      m_known = 1; m_ctrl_known = 1; m_fields_known = 1; m_rdc = 1; m_immc = 1;
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
      m_op = 0; m_rd = 0; m_a = 0; m_b = 0; m_imm = 0; m_pc = 0;
    end else if (m_known && Flush) begin
      m_valid = 0; m_ctrl_known = 0; m_fields_known = 0;
    end else if (m_known && exp_stall) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_ctrl_known = 1; m_fields_known = 0;
      m_rd = d.rd;
    end else if (m_known) begin
      m_valid = IF_Valid; m_ctrl_known = 1; m_fields_known = IF_Valid;
      m_rw = IF_Valid && d.rw; m_mr = IF_Valid && d.mr; m_mw = IF_Valid && d.mw;
      m_op = IF_Instr[15:12]; m_rd = d.rd; m_rdc = d.rdc; m_imm = d.imm; m_immc = d.immc;
      m_a = RData1; m_b = RData2; m_pc = IF_PC;
    end
  end

  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic [15:0] d1, input logic [15:0] d2, input logic fl);
    IF_Valid = v; IF_Instr = ins; IF_PC = pc; RData1 = d1; RData2 = d2; Flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b0;
    drive(1, 16'h0312, 16'h0001, 16'h0005, 16'h0007, 0);
    tick(); tick();
    $display("reset: EX_Valid=%0b Stall=%0b", EX_Valid, Stall);
    chk("rst_valid", EX_Valid, 0);
    chk("rst_stall", Stall, 0);
    chk("rst_rw", EX_RegWrite, 0);
    chk("rst_a", EX_A, 0);

    Reset = 1'b1;
    drive(1, 16'h0312, 16'h0001, 16'h0005, 16'h0007, 0);
    chk("add_ra1", RAddr1, 1);
    chk("add_ra2", RAddr2, 2);
    tick();
    $display("ADD: op=%0h rd=%0d A=%h B=%h rw=%0b", EX_Op, EX_Rd, EX_A, EX_B, EX_RegWrite);
    chk("add_valid", EX_Valid, 1);
    chk("add_op", EX_Op, 0);
    chk("add_rd", EX_Rd, 3);
    chk("add_a", EX_A, 16'h0005);
    chk("add_b", EX_B, 16'h0007);
    chk("add_rw", EX_RegWrite, 1);

    drive(1, 16'h842F, 16'h0002, 16'h0010, 16'h0000, 0);
    tick();
    $display("LW: rd=%0d imm=%h mr=%0b", EX_Rd, EX_Imm, EX_MemRead);
    chk("lw_imm", EX_Imm, 16'hFFFF);
    chk("lw_mr", EX_MemRead, 1);
    drive(1, 16'h0541, 16'h0003, 16'h0099, 16'h0011, 0);
    chk("lu_stall", Stall, 1);
    chk("lu_ra1", RAddr1, 4);
    tick();
    $display("bubble: EX_Valid=%0b Stall=%0b", EX_Valid, Stall);
    chk("bub_valid", EX_Valid, 0);
    chk("bub_mr", EX_MemRead, 0);
    chk("bub_stall", Stall, 0);
    drive(1, 16'h0541, 16'h0003, 16'h0042, 16'h0011, 0);
    tick();
    $display("ADD after bubble: rd=%0d A=%h", EX_Rd, EX_A);
    chk("add2_valid", EX_Valid, 1);
    chk("add2_rd", EX_Rd, 5);
    chk("add2_a", EX_A, 16'h0042);

    drive(1, 16'h842F, 16'h0004, 16'h0000, 16'h0000, 0);
    tick();
    drive(1, 16'h4544, 16'h0005, 16'h0003, 16'h0000, 0);
    chk("sll_stall", Stall, 1);
    tick(); tick();
    $display("SLL: op=%0h imm=%h", EX_Op, EX_Imm);
    chk("sll_imm", EX_Imm, 16'h0004);

    drive(1, 16'h802F, 16'h0006, 16'h0000, 16'h0000, 0);
    tick();
    chk("lw0_rw", EX_RegWrite, 0);
    drive(1, 16'h0501, 16'h0007, 16'h0000, 16'h0000, 0);
    $display("LW R0 then reader: Stall=%0b", Stall);
    chk("lw0_nostall", Stall, 0);
    tick();

    drive(1, 16'h842F, 16'h0008, 16'h0000, 16'h0000, 0);
    tick();
    drive(1, 16'h0541, 16'h0009, 16'h0001, 16'h0002, 1);
    chk("fl_stall", Stall, 1);
    tick();
    $display("flush+stall: EX_Valid=%0b", EX_Valid);
    chk("fl_valid", EX_Valid, 0);
    drive(1, 16'h0541, 16'h0009, 16'h0001, 16'h0002, 0);
    tick();

    drive(1, 16'hE123, 16'h000A, 16'h0000, 16'h0000, 0);
    tick();
    $display("JAL: rd=%0d imm=%h rw=%0b", EX_Rd, EX_Imm, EX_RegWrite);
    chk("jal_rd", EX_Rd, 15);
    chk("jal_imm", EX_Imm, 16'h0123);
    chk("jal_rw", EX_RegWrite, 1);
    drive(1, 16'hA2AB, 16'h000B, 16'h1200, 16'h0000, 0);
    chk("lhb_ra1", RAddr1, 2);
    tick();
    $display("LHB: imm=%h", EX_Imm);
    chk("lhb_imm", EX_Imm, 16'h00AB);

    drive(1, 16'h9321, 16'h000C, 16'h0100, 16'h0BEE, 0);
    chk("sw_ra1", RAddr1, 2);
    chk("sw_ra2", RAddr2, 3);
    tick();
    chk("sw_mw", EX_MemWrite, 1);
    chk("sw_rw", EX_RegWrite, 0);
    drive(1, 16'hC3F0, 16'h000D, 16'h0000, 16'h0000, 0);
    tick();
    $display("B: rd=%0d imm=%h", EX_Rd, EX_Imm);
    chk("b_imm", EX_Imm, 16'hFFF0);
    drive(1, 16'hDFFF, 16'h000E, 16'h0000, 16'h0000, 0);
    tick();
    chk("j_imm", EX_Imm, 16'h0FFF);
    drive(1, 16'hF000, 16'h000F, 16'h0000, 16'h0000, 0);
    tick();
    chk("nop_rw", EX_RegWrite, 0);
    drive(0, 16'h0312, 16'h0010, 16'h0000, 16'h0000, 0);
    tick();
    $display("idle: EX_Valid=%0b", EX_Valid);
    chk("idle_valid", EX_Valid, 0);

    drive(1, 16'h842F, 16'h0011, 16'h0000, 16'h0000, 0);
    tick();
    Reset = 1'b0;
    drive(1, 16'h0541, 16'h0012, 16'h0000, 16'h0000, 0);
    chk("rstmid_stall", Stall, 0);
    tick();
    $display("reset mid-stall: EX_Valid=%0b rd=%0d", EX_Valid, EX_Rd);
    chk("rstmid_valid", EX_Valid, 0);
    chk("rstmid_rd", EX_Rd, 0);
    Reset = 1'b1;
    drive(1, 16'h0312, 16'h0013, 16'h0001, 16'h0002, 0);
    tick();
    @(negedge Clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
